// File: rtl/risc_processor.sv
// risc_processor: non-pipelined 16-bit RISC core, one instruction per clock.
// Eight general registers, 256-word instruction ROM and 256x16 data RAM,
// one input port, one registered output port, single-level interrupt.
// The program image is supplied as a packed parameter; word n occupies
// bits [16n+15:16n].
module risc_processor #(
  parameter logic [7:0]    INT_VECTOR = 8'h10,
  parameter logic [4095:0] IMEM_INIT  = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] inputPort,
  input  logic        interrupt,
  output logic [15:0] outputPort
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_regs [8];
  logic [7:0]  r_pc, r_epc;
  logic        r_z, r_n, r_c, r_ie;
  logic [15:0] r_out;
  logic [15:0] r_dmem [256] = '{default: '0};

  logic [15:0] w_instr;
  logic [3:0]  w_op;
  logic [2:0]  w_rd, w_rs;
  logic [7:0]  w_imm;
  logic [15:0] w_rd_val, w_rs_val;

  logic [7:0]  w_pc_nxt, w_epc_nxt;
  logic        w_z_nxt, w_n_nxt, w_c_nxt, w_ie_nxt;
  logic [15:0] w_out_nxt;
  logic        w_reg_we, w_mem_we, w_set_zn;
  logic [15:0] w_reg_wdata;
  logic [16:0] w_wide;

  assign w_instr  = IMEM_INIT[{r_pc, 4'b0000} +: 16];
  assign w_op     = w_instr[15:12];
  assign w_rd     = w_instr[11:9];
  assign w_rs     = w_instr[8:6];
  assign w_imm    = w_instr[7:0];
  assign w_rd_val = r_regs[w_rd];
  assign w_rs_val = r_regs[w_rs];

  assign outputPort = r_out;

  // Next-state, decode and execute for the instruction at PC.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_epc_nxt   = r_epc;
    w_ie_nxt    = r_ie;
    w_z_nxt     = r_z;
    w_n_nxt     = r_n;
    w_c_nxt     = r_c;
    w_out_nxt   = r_out;
    w_reg_we    = 1'b0;
    w_mem_we    = 1'b0;
    w_set_zn    = 1'b0;
    w_reg_wdata = '0;
    w_wide      = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (interrupt && r_ie) begin
          // The instruction at PC is skipped and resumed by RTI.
          w_epc_nxt = r_pc;
          w_pc_nxt  = INT_VECTOR;
          w_ie_nxt  = 1'b0;
        end else begin
          w_pc_nxt = r_pc + 8'd1;
          case (w_op)
            4'h0: begin end
            4'h1: w_state_nxt = S_HALT;
            4'h2: begin
              w_reg_we    = 1'b1;
              w_reg_wdata = w_rs_val;
            end
            4'h3: begin
              w_wide      = {1'b0, w_rd_val} + {1'b0, w_rs_val};
              w_reg_we    = 1'b1;
              w_reg_wdata = w_wide[15:0];
              w_c_nxt     = w_wide[16];
              w_set_zn    = 1'b1;
            end
            4'h4: begin
              w_wide      = {1'b0, w_rd_val} - {1'b0, w_rs_val};
              w_reg_we    = 1'b1;
              w_reg_wdata = w_wide[15:0];
              w_c_nxt     = w_wide[16];
              w_set_zn    = 1'b1;
            end
            4'h5: begin
              w_reg_we    = 1'b1;
              w_reg_wdata = w_rd_val & w_rs_val;
              w_set_zn    = 1'b1;
            end
            4'h6: begin
              w_reg_we    = 1'b1;
              w_reg_wdata = w_rd_val | w_rs_val;
              w_set_zn    = 1'b1;
            end
            4'h7: begin
              w_reg_we    = 1'b1;
              w_reg_wdata = ~w_rd_val;
              w_set_zn    = 1'b1;
            end
            4'h8: begin
              w_reg_we    = 1'b1;
              w_reg_wdata = {{8{w_imm[7]}}, w_imm};
            end
            4'h9: begin
              w_reg_we    = 1'b1;
              w_reg_wdata = inputPort;
            end
            4'hA: w_out_nxt = w_rd_val;
            4'hB: begin
              w_reg_we    = 1'b1;
              w_reg_wdata = r_dmem[w_rs_val[7:0]];
            end
            4'hC: w_mem_we = 1'b1;
            4'hD: begin
              if (r_z) w_pc_nxt = w_imm;
            end
            4'hE: w_pc_nxt = w_imm;
            4'hF: begin
              w_pc_nxt = r_epc;
              w_ie_nxt = 1'b1;
            end
          endcase
          if (w_set_zn) begin
            w_z_nxt = (w_reg_wdata == 16'h0000);
            w_n_nxt = w_reg_wdata[15];
          end
        end
      end
      default: begin end
    endcase
  end

  // Mode register; reset wins over start.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Architectural state; reset aborts the instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) r_regs[i] <= '0;
      r_pc  <= '0;
      r_epc <= '0;
      r_z   <= 1'b0;
      r_n   <= 1'b0;
      r_c   <= 1'b0;
      r_ie  <= 1'b1;
      r_out <= '0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_epc <= w_epc_nxt;
      r_z   <= w_z_nxt;
      r_n   <= w_n_nxt;
      r_c   <= w_c_nxt;
      r_ie  <= w_ie_nxt;
      r_out <= w_out_nxt;
      if (w_reg_we) r_regs[w_rd] <= w_reg_wdata;
    end
  end

  // Data RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && w_mem_we) r_dmem[w_rs_val[7:0]] <= w_rd_val;
  end

endmodule

// File: tb/tb_risc_processor.sv
// Self-checking bench for risc_processor: runs one fixed program image
// through three reset/start sessions (I/O + ALU + memory + wrap,
// interrupt, halt) and compares against bench-computed expectations.
module tb_risc_processor;

  function automatic logic [4095:0] build_prog();
    logic [4095:0] p;
    p = '0;
    // I/O stream, then branch on the last captured value
    p[16*'h00 +: 16] = 16'h9200; // IN  R1
    p[16*'h01 +: 16] = 16'hA200; // OUT R1
    p[16*'h02 +: 16] = 16'h9200;
    p[16*'h03 +: 16] = 16'hA200;
    p[16*'h04 +: 16] = 16'h9200;
    p[16*'h05 +: 16] = 16'hA200;
    p[16*'h06 +: 16] = 16'h9200;
    p[16*'h07 +: 16] = 16'hA200;
    p[16*'h08 +: 16] = 16'h5240; // AND R1,R1
    p[16*'h09 +: 16] = 16'hD00C; // JZ  0x0C
    p[16*'h0A +: 16] = 16'hE030; // JMP 0x30
    p[16*'h0C +: 16] = 16'h1000; // HLT
    p[16*'h0D +: 16] = 16'h7200; // NOT R1
    p[16*'h0E +: 16] = 16'hA200; // OUT R1
    // interrupt handler
    p[16*'h10 +: 16] = 16'h8E22; // LDI R7,0x22
    p[16*'h11 +: 16] = 16'hAE00; // OUT R7
    p[16*'h12 +: 16] = 16'hF000; // RTI
    // ALU / flags
    p[16*'h30 +: 16] = 16'h827F; // LDI R1,0x7F
    p[16*'h31 +: 16] = 16'h8401; // LDI R2,0x01
    p[16*'h32 +: 16] = 16'h3280; // ADD R1,R2
    p[16*'h33 +: 16] = 16'hA200; // OUT R1
    p[16*'h34 +: 16] = 16'h86FF; // LDI R3,0xFF
    p[16*'h35 +: 16] = 16'h3680; // ADD R3,R2
    p[16*'h36 +: 16] = 16'hA600; // OUT R3
    p[16*'h37 +: 16] = 16'h4480; // SUB R2,R2
    p[16*'h38 +: 16] = 16'hD050; // JZ  0x50
    p[16*'h39 +: 16] = 16'hA200; // OUT R1 (must be skipped)
    // memory
    p[16*'h50 +: 16] = 16'h8805; // LDI R4,0x05
    p[16*'h51 +: 16] = 16'hC300; // STM R1 -> [R4]
    p[16*'h52 +: 16] = 16'hBB00; // LDM R5 <- [R4]
    p[16*'h53 +: 16] = 16'hAA00; // OUT R5
    p[16*'h54 +: 16] = 16'hE0FE; // JMP 0xFE
    // PC wrap
    p[16*'hFE +: 16] = 16'h7C00; // NOT R6
    p[16*'hFF +: 16] = 16'hAC00; // OUT R6
    return p;
  endfunction

  localparam logic [4095:0] PROG = build_prog();

  logic        clk = 1'b0;
  logic        rst, start, interrupt;
  logic [15:0] inputPort, outputPort;

  risc_processor #(
    .INT_VECTOR (8'h10),
    .IMEM_INIT  (PROG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .inputPort  (inputPort),
    .interrupt  (interrupt),
    .outputPort (outputPort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] in_val;
    logic [15:0] junk;
    logic [15:0] exp_out;
  } io_vec_t;

  io_vec_t     io_tab [8];
  logic [15:0] sb_q [$];
  int          n_pass  = 0;
  int          n_total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
  endtask

  task automatic sb_pop_chk(input string name);
    if (sb_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: got empty scoreboard, expected an entry", name);
    end else begin
      chk(name, outputPort, sb_q.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; interrupt = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Four IN/OUT pairs; input changes every cycle, junk during the OUT cycle.
  task automatic run_io(input int base, input string tag);
    for (int i = 0; i < 4; i++) begin
      inputPort = io_tab[base+i].in_val;
      sb_q.push_back(io_tab[base+i].exp_out);
      tick();
      if (i == 0) chk({tag, "_pc_after_first"}, 16'(dut.r_pc), 16'h0001);
      inputPort = io_tab[base+i].junk;
      tick();
      sb_pop_chk($sformatf("%s_out%0d", tag, i));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1);
  end

  initial begin
    io_tab[0] = '{16'h0030, 16'hFFCF, 16'h0030};
    io_tab[1] = '{16'h0040, 16'h1111, 16'h0040};
    io_tab[2] = '{16'h0500, 16'h2222, 16'h0500};
    io_tab[3] = '{16'h0100, 16'h3333, 16'h0100};
    io_tab[4] = '{16'hAAAA, 16'h4444, 16'hAAAA};
    io_tab[5] = '{16'h5555, 16'h6666, 16'h5555};
    io_tab[6] = '{16'h0F0F, 16'h7777, 16'h0F0F};
    io_tab[7] = '{16'h0000, 16'h8888, 16'h0000};

    rst = 1'b0; start = 1'b0; interrupt = 1'b0; inputPort = '0;

    // ---- session A: reset/start, I/O, ALU, memory, wrap
    do_reset();
    interrupt = 1'b1;               // ignored while idle
    repeat (3) tick();
    interrupt = 1'b0;
    chk("idle_pc", 16'(dut.r_pc), 16'h0000);
    chk("idle_out", outputPort, 16'h0000);
    chk("idle_mode", 16'(dut.r_state), 16'h0000);
    chk("idle_epc", 16'(dut.r_epc), 16'h0000);
    start_run();
    chk("run_mode", 16'(dut.r_state), 16'h0001);
    chk("run_pc0", 16'(dut.r_pc), 16'h0000);

    run_io(0, "ioA");
    repeat (3) tick();              // AND, JZ (not taken), JMP
    chk("jmp_pc", 16'(dut.r_pc), 16'h0030);
    repeat (3) tick();              // LDI, LDI, ADD
    chk("add1_r1", dut.r_regs[1], 16'h0080);
    chk("add1_z", 16'(dut.r_z), 16'h0000);
    chk("add1_n", 16'(dut.r_n), 16'h0000);
    chk("add1_c", 16'(dut.r_c), 16'h0000);
    sb_q.push_back(16'h0080);
    tick();
    sb_pop_chk("out_add1");
    repeat (2) tick();              // LDI R3,0xFF ; ADD R3,R2
    chk("add2_r3", dut.r_regs[3], 16'h0000);
    chk("add2_z", 16'(dut.r_z), 16'h0001);
    chk("add2_c", 16'(dut.r_c), 16'h0001);
    chk("add2_n", 16'(dut.r_n), 16'h0000);
    sb_q.push_back(16'h0000);
    tick();
    sb_pop_chk("out_add2");
    tick();                         // SUB R2,R2
    chk("sub_r2", dut.r_regs[2], 16'h0000);
    chk("sub_z", 16'(dut.r_z), 16'h0001);
    chk("sub_c", 16'(dut.r_c), 16'h0000);
    tick();                         // JZ 0x50
    chk("jz_pc", 16'(dut.r_pc), 16'h0050);
    repeat (3) tick();              // LDI, STM, LDM
    chk("ldm_r5", dut.r_regs[5], 16'h0080);
    sb_q.push_back(16'h0080);
    tick();
    sb_pop_chk("out_ldm");
    tick();                         // JMP 0xFE
    chk("jmp_fe_pc", 16'(dut.r_pc), 16'h00FE);
    tick();                         // NOT R6
    chk("not_r6", dut.r_regs[6], 16'hFFFF);
    chk("not_n", 16'(dut.r_n), 16'h0001);
    chk("not_z", 16'(dut.r_z), 16'h0000);
    chk("not_c_kept", 16'(dut.r_c), 16'h0000);
    sb_q.push_back(16'hFFFF);
    tick();
    sb_pop_chk("out_not");
    chk("wrap_pc", 16'(dut.r_pc), 16'h0000);

    // ---- session B: interrupt at PC=3
    do_reset();
    start_run();
    inputPort = 16'h1234;
    sb_q.push_back(16'h1234);
    tick();
    inputPort = 16'hDEAD;
    tick();
    sb_pop_chk("irq_pre_out");
    inputPort = 16'h5678;
    tick();
    inputPort = 16'hBEEF;
    interrupt = 1'b1;
    tick();
    chk("irq_pc", 16'(dut.r_pc), 16'h0010);
    chk("irq_epc", 16'(dut.r_epc), 16'h0003);
    chk("irq_ie", 16'(dut.r_ie), 16'h0000);
    chk("irq_out_held", outputPort, 16'h1234);
    tick();                         // second request inside handler
    chk("irq2_pc", 16'(dut.r_pc), 16'h0011);
    chk("irq2_epc", 16'(dut.r_epc), 16'h0003);
    chk("hnd_r7", dut.r_regs[7], 16'h0022);
    interrupt = 1'b0;
    sb_q.push_back(16'h0022);
    tick();
    sb_pop_chk("hnd_out");
    interrupt = 1'b1;               // still masked during RTI
    tick();
    interrupt = 1'b0;
    chk("rti_pc", 16'(dut.r_pc), 16'h0003);
    chk("rti_ie", 16'(dut.r_ie), 16'h0001);
    sb_q.push_back(16'h5678);
    tick();
    sb_pop_chk("resumed_out");
    chk("resumed_pc", 16'(dut.r_pc), 16'h0004);

    // ---- session C: reset values, then HLT freeze
    do_reset();
    chk("rst_r1", dut.r_regs[1], 16'h0000);
    chk("rst_r7", dut.r_regs[7], 16'h0000);
    chk("rst_epc", 16'(dut.r_epc), 16'h0000);
    chk("rst_out", outputPort, 16'h0000);
    chk("rst_mode", 16'(dut.r_state), 16'h0000);
    start_run();
    run_io(4, "ioC");
    repeat (3) tick();              // AND (Z=1), JZ 0x0C, HLT
    chk("hlt_mode", 16'(dut.r_state), 16'h0002);
    chk("hlt_pc", 16'(dut.r_pc), 16'h000D);
    chk("hlt_z", 16'(dut.r_z), 16'h0001);
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      interrupt = ~interrupt;
      tick();
    end
    start = 1'b0; interrupt = 1'b0;
    chk("hlt_mode_frozen", 16'(dut.r_state), 16'h0002);
    chk("hlt_pc_frozen", 16'(dut.r_pc), 16'h000D);
    chk("hlt_out_frozen", outputPort, 16'h0000);
    chk("hlt_r1_frozen", dut.r_regs[1], 16'h0000);
    chk("hlt_epc_frozen", 16'(dut.r_epc), 16'h0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_hlt_mode", 16'(dut.r_state), 16'h0000);
    chk("post_hlt_pc", 16'(dut.r_pc), 16'h0000);
    chk("post_hlt_ie", 16'(dut.r_ie), 16'h0001);
    chk("post_hlt_z", 16'(dut.r_z), 16'h0000);
    chk("post_hlt_out", outputPort, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
